// File: rtl/score_mem_arbiter.sv
// Shares the single-port game memory between gameplay (A), display (B) and a high-score engine.
// Optional macro SCORE_ARB_RR_EN selects round-robin A/B arbitration instead of fixed A-over-B priority.
module score_mem_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int RD_LATENCY = 1,
  parameter int SCORE_ADDR = 0,
  parameter int TOP_ADDR   = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [7:0]        a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [7:0]        b_rdata,
  input  logic              game_over,
  output logic              hs_busy,
  output logic              hs_done,
  output logic              hs_new_record,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_wren,
  input  logic [7:0]        mem_q
);

  localparam logic [ADDR_W-1:0] SCORE_A = ADDR_W'(SCORE_ADDR);
  localparam logic [ADDR_W-1:0] TOP_A   = ADDR_W'(TOP_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_SCORE, S_RD_TOP, S_WAIT, S_CMP, S_WR, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic              rec_q, rec_d;
  logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              mem_wren_q, mem_wren_d;
  logic [7:0]        score_q, top_q;
  logic [7:0]        a_rdata_q, b_rdata_q;

  // Read-return tags: bit0 port A, bit1 port B, bit2 engine score, bit3 engine top
  logic [3:0]        pipe_q [RD_LATENCY];
  logic [3:0]        pipe_in, pipe_out;

  logic              go, port_rd_busy, port_ok;
  logic              a_cand, b_cand, prio_a, grant_a, grant_b;

  assign pipe_in  = {state_q == S_RD_TOP, state_q == S_RD_SCORE,
                     b_gnt_q & ~mem_wren_q, a_gnt_q & ~mem_wren_q};
  assign pipe_out = pipe_q[RD_LATENCY-1];

  // A read whose data returns this very cycle is already complete for draining purposes.
  always_comb begin
    port_rd_busy = (a_gnt_q | b_gnt_q) & ~mem_wren_q;
    for (int i = 0; i < RD_LATENCY - 1; i++) begin
      port_rd_busy = port_rd_busy | (|pipe_q[i][1:0]);
    end
  end

  assign go      = pend_q | game_over;
  assign port_ok = ((state_q == S_IDLE) || (state_q == S_DONE)) && !go;
  assign a_cand  = a_req & ~a_gnt_q;
  assign b_cand  = b_req & ~b_gnt_q;
  assign grant_a = port_ok & a_cand & (~b_cand | prio_a);
  assign grant_b = port_ok & b_cand & ~grant_a;

`ifdef SCORE_ARB_RR_EN
  logic rr_q, rr_d;  // 0: A holds priority next

  assign prio_a = ~rr_q;
  assign rr_d   = grant_a ? 1'b1 : (grant_b ? 1'b0 : rr_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rr_q <= 1'b0;
    else         rr_q <= rr_d;
  end
`else
  assign prio_a = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q | game_over;
    rec_d      = rec_q;
    a_gnt_d    = grant_a;
    b_gnt_d    = grant_b;
    mem_wren_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    if (grant_a) begin
      mem_addr_d = a_addr;
      mem_data_d = a_wdata;
      mem_wren_d = a_we;
    end else if (grant_b) begin
      mem_addr_d = b_addr;
      mem_data_d = b_wdata;
      mem_wren_d = b_we;
    end

    case (state_q)
      S_IDLE: begin
        if (go && !port_rd_busy) begin
          state_d    = S_RD_SCORE;
          pend_d     = 1'b0;
          mem_addr_d = SCORE_A;
        end
      end
      S_RD_SCORE: begin
        state_d    = S_RD_TOP;
        mem_addr_d = TOP_A;
      end
      S_RD_TOP: state_d = S_WAIT;
      S_WAIT: begin
        if (pipe_out[3]) state_d = S_CMP;
      end
      S_CMP: begin
        if (score_q > top_q) begin
          state_d    = S_WR;
          rec_d      = 1'b1;
          mem_wren_d = 1'b1;
          mem_addr_d = TOP_A;
          mem_data_d = score_q;
        end else begin
          state_d = S_DONE;
          rec_d   = 1'b0;
        end
      end
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      pend_q     <= 1'b0;
      rec_q      <= 1'b0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_wren_q <= 1'b0;
      score_q    <= '0;
      top_q      <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      rec_q      <= rec_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_wren_q <= mem_wren_d;
      if (pipe_out[2]) score_q   <= mem_q;
      if (pipe_out[3]) top_q     <= mem_q;
      if (pipe_out[0]) a_rdata_q <= mem_q;
      if (pipe_out[1]) b_rdata_q <= mem_q;
      pipe_q[0] <= pipe_in;
      for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Read data is passed straight through in its return cycle, then held.
  assign a_rvalid      = pipe_out[0];
  assign b_rvalid      = pipe_out[1];
  assign a_rdata       = pipe_out[0] ? mem_q : a_rdata_q;
  assign b_rdata       = pipe_out[1] ? mem_q : b_rdata_q;
  assign a_gnt         = a_gnt_q;
  assign b_gnt         = b_gnt_q;
  assign mem_addr      = mem_addr_q;
  assign mem_data      = mem_data_q;
  assign mem_wren      = mem_wren_q;
  assign hs_busy       = (state_q != S_IDLE);
  assign hs_done       = (state_q == S_DONE);
  assign hs_new_record = (state_q == S_DONE) & rec_q;

endmodule

// File: doc/score_mem_arbiter.md
Name: score_mem_arbiter

Overview:
- Sequences and shares the single-port 32x8 game memory between two requesters:
  - port A: gameplay datapath, score read-modify-write.
  - port B: hex score display, periodic reads.
- Contains an internal high-score engine. On a game-over pulse it reads the current score and the stored top score, then writes back the larger value.
- Sits between the datapath/display logic and the game memory. It replaces their direct wiring to the memory address/data/wren/q pins.

Parameters:
- ADDR_W, 5, memory address width.
- RD_LATENCY, 1, cycles from the presented read address to valid mem_q. Legal values 1 or 2.
- SCORE_ADDR, 0, address of the current player score.
- TOP_ADDR, 1, address of the stored top score.

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- a_req  in  1  port A request; held with a_we/a_addr/a_wdata stable until a_gnt
- a_we  in  1  port A: 1 = write, 0 = read
- a_addr  in  ADDR_W  port A address
- a_wdata  in  8  port A write data
- a_gnt  out  1  port A access presented to memory this cycle
- a_rvalid  out  1  port A read data valid
- a_rdata  out  8  port A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same widths/meaning for port B
- game_over  in  1  single-cycle pulse starting a high-score update
- hs_busy  out  1  high-score engine owns the memory
- hs_done  out  1  one-cycle pulse when the update completes
- hs_new_record  out  1  one-cycle pulse, coincident with hs_done, when the top score was replaced
- mem_addr  out  ADDR_W  memory address
- mem_data  out  8  memory write data
- mem_wren  out  1  memory write enable
- mem_q  in  8  memory read data

Behaviour:
- Reset values (resetn low, asynchronous):
  - All gnt, rvalid, hs_done, hs_new_record, hs_busy, mem_wren = 0.
  - mem_addr, mem_data, a_rdata, b_rdata = 0.
  - FSM in IDLE, game-over pending flag cleared, round-robin pointer at A.
  - Read-return pipeline flushed: no rvalid after reset release for accesses issued before reset.
- Memory bus outputs are registered. Arbitration decided in cycle t is presented in cycle t+1, with the matching gnt high for exactly that cycle.
- Requester handshake:
  - The requester sees gnt and may change or drop req on the following edge.
  - The arbiter masks a requester whose gnt is currently high, so no duplicate grant is issued.
  - Maximum rate is one access per requester every 2 cycles. A and B may be granted in consecutive cycles.
- Reads: x_rvalid pulses and x_rdata = mem_q exactly RD_LATENCY cycles after the x_gnt cycle. x_rdata holds its value until the next rvalid.
- Writes: mem_wren = 1 only in the gnt cycle. No rvalid is produced.
- Arbitration (default, without the optional feature): fixed priority, A over B.
- High-score FSM states:
  - IDLE → RD_SCORE on pending game-over, once no issued port read is outstanding.
  - RD_SCORE: present SCORE_ADDR read.
  - RD_TOP: present TOP_ADDR read.
  - WAIT: hold until both reads return (RD_LATENCY).
  - CMP: unsigned 8-bit compare.
    - If score > top, go to WR.
    - If score ≤ top, go to DONE with no write. Equal values do not write.
  - WR: mem_wren = 1, mem_addr = TOP_ADDR, mem_data = score.
  - DONE: hs_done pulse, then IDLE.
- hs_busy is high from the RD_SCORE cycle through DONE. No port gnt is issued while hs_busy is high; requests simply wait.
- game_over pulses:
  - A pulse while busy sets the pending flag, and a second full update runs after DONE.
  - Multiple pulses while busy collapse into one.
- A game_over pulse in the same cycle as port requests: the engine wins the next free slot once outstanding reads drain. The pending port request is served after DONE.
- Reset mid-update: the FSM aborts immediately. No partial write completes after resetn deasserts.

Optional Feature:
- Macro: SCORE_ARB_RR_EN.
- Defined: A/B arbitration is round-robin. The pointer moves to the other port after each grant, so under continuous A and B requests the grants alternate A,B,A,B. The high-score engine still preempts both ports.
- Undefined: fixed priority, A always wins. B can starve under continuous A traffic.

Test Plan:
- Reset, then A read addr 3 (mem holds 8'h2A) → a_gnt one cycle later, a_rvalid with a_rdata = 8'h2A after RD_LATENCY, b_* silent.
- A and B both request continuously → default: A granted every 2nd cycle and B in the gaps. With SCORE_ARB_RR_EN: strict A,B,A,B alternation.
- score = 8'd15, top = 8'd9, game_over pulse → reads of addr 0 and 1, write 8'd15 to addr 1, hs_done = hs_new_record = 1 for one cycle.
- score = 8'd9, top = 8'd9 → no mem_wren, hs_done = 1, hs_new_record = 0.
- Second game_over pulse during hs_busy → exactly one additional update sequence after DONE. A request issued during hs_busy gets no gnt until hs_busy falls.
- resetn low during WR state → mem_wren drops asynchronously, all outputs at reset values, FSM in IDLE, no rvalid after release.
